// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: zero-latency icache hit path, byte-serial
// refill of a 32-bit word on a miss, icache fill and response, and
// flush/drain handling so that no stale byte is ever matched to a new miss.
//
// state | meaning
// IDLE  | hit path open; a miss latches the word address and starts a fill
// MISS  | issuing byte reads and collecting returned bytes
// RESP  | one cycle: write the word to the icache, hand it to fetch if wanted
// DRAIN | fill was flushed; swallow the bytes memory still owes us
module ifetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  output logic [31:0] fetch_inst,
  input  logic        flush,
  output logic [31:0] ic_addr,
  input  logic        ic_hit,
  input  logic [31:0] ic_inst,
  output logic        ic_wr,
  output logic [31:0] ic_wdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_dvalid,
  input  logic [7:0]  mem_din
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MISS  = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_miss_pc;
  logic [31:0] w_miss_pc_nxt;
  logic [2:0]  r_issue_cnt;
  logic [2:0]  w_issue_nxt;
  logic [2:0]  r_recv_cnt;
  logic [2:0]  w_recv_nxt;
  logic [31:0] r_buf;
  logic [31:0] w_buf_nxt;

  logic [31:0] w_fetch_line;
  logic        w_pc_match;
  logic [2:0]  w_recv_inc;
  logic        w_unused;

  assign w_fetch_line = {fetch_pc[31:2], 2'b00};
  assign w_pc_match   = (fetch_pc[31:2] == r_miss_pc[31:2]);
  assign w_recv_inc   = r_recv_cnt + 3'd1;
  assign w_unused     = ^fetch_pc[1:0];

  // The fill word is presented continuously; it only matters while ic_wr is high.
  assign ic_wdata = r_buf;

  // Next-state, counter/buffer updates and all handshake outputs.
  // With rdy low every next value defaults to the current one and every
  // strobe stays at its inactive default, so the whole block freezes.
  always_comb begin
    w_state_nxt   = r_state;
    w_miss_pc_nxt = r_miss_pc;
    w_issue_nxt   = r_issue_cnt;
    w_recv_nxt    = r_recv_cnt;
    w_buf_nxt     = r_buf;
    fetch_ready   = 1'b0;
    fetch_inst    = 32'h0;
    ic_addr       = r_miss_pc;
    ic_wr         = 1'b0;
    mem_req       = 1'b0;
    mem_addr      = 32'h0;

    case (r_state)
      S_IDLE: begin
        ic_addr = w_fetch_line;
        if (rdy && fetch_valid && !flush) begin
          if (ic_hit) begin
            fetch_ready = 1'b1;
            fetch_inst  = ic_inst;
          end else begin
            w_miss_pc_nxt = w_fetch_line;
            w_issue_nxt   = 3'd0;
            w_recv_nxt    = 3'd0;
            w_state_nxt   = S_MISS;
          end
        end
      end

      S_MISS: begin
        mem_addr = r_miss_pc + {29'd0, r_issue_cnt};
        mem_req  = rdy && !flush && (r_issue_cnt < 3'd4);
        if (rdy) begin
          if (mem_req && mem_gnt) begin
            w_issue_nxt = r_issue_cnt + 3'd1;
          end
          if (mem_dvalid && !r_recv_cnt[2]) begin
            w_buf_nxt[{r_recv_cnt[1:0], 3'b000} +: 8] = mem_din;
            w_recv_nxt = w_recv_inc;
          end
          // A flush only needs a drain if bytes are still owed after this edge.
          if (flush) begin
            w_state_nxt = (w_recv_nxt == r_issue_cnt) ? S_IDLE : S_DRAIN;
          end else if (mem_dvalid && (r_recv_cnt == 3'd3)) begin
            w_state_nxt = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (rdy) begin
          // The word is good even under flush, so the icache is still filled.
          ic_wr = 1'b1;
          if (!flush && fetch_valid && w_pc_match) begin
            fetch_ready = 1'b1;
            fetch_inst  = r_buf;
          end
          w_state_nxt = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (rdy) begin
          if (mem_dvalid) begin
            w_recv_nxt = w_recv_inc;
          end
          if (w_recv_nxt == r_issue_cnt) begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, miss address, byte counters and assembly buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_miss_pc   <= 32'h0;
      r_issue_cnt <= 3'd0;
      r_recv_cnt  <= 3'd0;
      r_buf       <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_miss_pc   <= w_miss_pc_nxt;
      r_issue_cnt <= w_issue_nxt;
      r_recv_cnt  <= w_recv_nxt;
      r_buf       <= w_buf_nxt;
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: small tagged icache, byte memory with in-order
// replies, and a transaction-level model of the outstanding fill.
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic [31:0] fetch_inst;
  logic        flush;
  logic [31:0] ic_addr;
  logic        ic_hit;
  logic [31:0] ic_inst;
  logic        ic_wr;
  logic [31:0] ic_wdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_dvalid;
  logic [7:0]  mem_din;

  int n_cmp = 0;
  int n_err = 0;

  ifetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .fetch_inst  (fetch_inst),
    .flush       (flush),
    .ic_addr     (ic_addr),
    .ic_hit      (ic_hit),
    .ic_inst     (ic_inst),
    .ic_wr       (ic_wr),
    .ic_wdata    (ic_wdata),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_dvalid  (mem_dvalid),
    .mem_din     (mem_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // icache: 256 entries indexed by word address bits, tagged by the rest
  logic        c_val [256];
  logic [21:0] c_tag [256];
  logic [31:0] c_dat [256];

  always_comb begin
    ic_hit  = c_val[ic_addr[9:2]] && (c_tag[ic_addr[9:2]] == ic_addr[31:10]);
    ic_inst = c_dat[ic_addr[9:2]];
  end

  // environment and model state
  logic [31:0] rq[$];
  logic [31:0] gnt_log[$];
  int          gnt_pol = 0;
  int          stall_cnt = 0;
  logic        hold_next = 1'b0;
  logic        rnd_data = 1'b0;
  int          wr_cnt = 0;
  logic [31:0] last_inst = 32'h0;

  logic        f_on = 1'b0;
  logic        f_dead = 1'b0;
  logic        f_done = 1'b0;
  logic [31:0] f_pc = 32'h0;
  int          f_sent = 0;
  logic [7:0]  f_got[$];

  function automatic logic [7:0] mb(input logic [31:0] a);
    logic [31:0] w;
    if (a[31:2] == 30'h80) begin
      w = 32'h00100093;
      return w[{a[1:0], 3'b000} +: 8];
    end
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  function automatic logic m_hit(input logic [31:0] a);
    return c_val[a[9:2]] && (c_tag[a[9:2]] == a[31:10]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    f_on   = 1'b0;
    f_dead = 1'b0;
    f_done = 1'b0;
    f_sent = 0;
    f_got.delete();
  endtask

  // One clock cycle, entered and left with clk low.
  task automatic cyc(input logic fv, input logic [31:0] pc, input logic fl,
                     input logic r, input logic do_rst);
    logic        g, dv, hold, mh;
    logic [7:0]  d;
    logic [31:0] al;
    logic        e_ready, e_req, e_wr;
    logic [31:0] e_inst, e_addr;
    logic        s_req, s_wr;
    logic [31:0] s_addr, s_icaddr, s_wdata;

    al = {pc[31:2], 2'b00};
    case (gnt_pol)
      0:       g = 1'b1;
      1:       g = ($urandom_range(0, 1) == 1);
      default: g = (stall_cnt == 3);
    endcase
    hold = hold_next || (rnd_data && ($urandom_range(0, 2) == 0));
    dv   = (rq.size() > 0) && !hold;
    d    = 8'h00;
    if (dv) d = mb(rq[0]);

    rdy = r; fetch_valid = fv; fetch_pc = pc; flush = fl;
    mem_gnt = g; mem_dvalid = dv; mem_din = d;
    #1;

    if (do_rst) begin
      rst = 1'b0;
      #1;
      chkb("rst_fetch_ready", fetch_ready, 1'b0);
      chk ("rst_fetch_inst",  fetch_inst,  32'h0);
      chkb("rst_mem_req",     mem_req,     1'b0);
      chk ("rst_mem_addr",    mem_addr,    32'h0);
      chkb("rst_ic_wr",       ic_wr,       1'b0);
      chk ("rst_ic_wdata",    ic_wdata,    32'h0);
      rst = 1'b1;
      m_reset();
      #1;
    end

    mh      = m_hit(al);
    e_ready = 1'b0; e_inst = 32'h0; e_req = 1'b0; e_addr = 32'h0; e_wr = 1'b0;
    if (f_done) begin
      e_wr    = r;
      e_ready = r && !fl && fv && (pc[31:2] == f_pc[31:2]);
      if (e_ready) e_inst = exp_word(f_pc);
      chk("resp_ic_addr", ic_addr, f_pc);
    end else if (!f_on) begin
      e_ready = r && fv && !fl && mh;
      if (e_ready) e_inst = c_dat[al[9:2]];
      chk("idle_ic_addr", ic_addr, al);
    end else if (!f_dead) begin
      e_req  = r && !fl && (f_sent < 4);
      e_addr = f_pc + 32'(f_sent);
    end

    chkb("fetch_ready", fetch_ready, e_ready);
    chk ("fetch_inst",  fetch_inst,  e_inst);
    chkb("mem_req",     mem_req,     e_req);
    if (e_req) chk("mem_addr", mem_addr, e_addr);
    chkb("ic_wr",       ic_wr,       e_wr);
    if (e_wr) chk("ic_wdata", ic_wdata, exp_word(f_pc));

    s_req = mem_req; s_addr = mem_addr; s_wr = ic_wr;
    s_icaddr = ic_addr; s_wdata = ic_wdata;
    if (fetch_ready) last_inst = fetch_inst;

    @(posedge clk);
    if (r) begin
      if (dv) void'(rq.pop_front());
      if (s_req && g) begin
        rq.push_back(s_addr);
        gnt_log.push_back(s_addr);
        stall_cnt = 0;
      end else if (s_req) begin
        stall_cnt++;
      end
      if (s_wr) begin
        c_val[s_icaddr[9:2]] = 1'b1;
        c_tag[s_icaddr[9:2]] = s_icaddr[31:10];
        c_dat[s_icaddr[9:2]] = s_wdata;
        wr_cnt++;
      end
      if (f_done) begin
        f_done = 1'b0;
        f_on   = 1'b0;
      end else if (!f_on) begin
        if (fv && !fl && !mh) begin
          f_on = 1'b1; f_dead = 1'b0; f_pc = al; f_sent = 0; f_got.delete();
        end
      end else begin
        if (e_req && g) f_sent++;
        if (dv) f_got.push_back(d);
        if (f_dead) begin
          if (f_got.size() == f_sent) f_on = 1'b0;
        end else if (fl) begin
          if (f_got.size() == f_sent) f_on = 1'b0;
          else f_dead = 1'b1;
        end else if (f_got.size() == 4) begin
          f_done = 1'b1;
        end
      end
    end
    hold_next = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_fill(input logic [31:0] pc, input logic start);
    logic done;
    done = 1'b0;
    if (start) begin
      gnt_log.delete();
      last_inst = 32'h0;
      cyc(1'b1, pc, 1'b0, 1'b1, 1'b0);
    end
    for (int k = 0; k < 100 && !done; k++) begin
      if (f_done) done = 1'b1;
      cyc(1'b1, pc, 1'b0, 1'b1, 1'b0);
    end
    chkb("fill_complete", done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pool [8];
    int          w0;

    for (int i = 0; i < 256; i++) begin
      c_val[i] = 1'b0; c_tag[i] = 22'h0; c_dat[i] = 32'h0;
    end
    rst = 1'b0; rdy = 1'b0; fetch_valid = 1'b0; fetch_pc = 32'h0; flush = 1'b0;
    mem_gnt = 1'b0; mem_dvalid = 1'b0; mem_din = 8'h00;
    #1;
    chkb("reset_fetch_ready", fetch_ready, 1'b0);
    chk ("reset_fetch_inst",  fetch_inst,  32'h0);
    chkb("reset_mem_req",     mem_req,     1'b0);
    chk ("reset_mem_addr",    mem_addr,    32'h0);
    chkb("reset_ic_wr",       ic_wr,       1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // hit at 0x100
    c_val[64] = 1'b1; c_tag[64] = 22'h0; c_dat[64] = 32'h00000013;
    last_inst = 32'h0;
    cyc(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
    chk("hit_inst", last_inst, 32'h00000013);

    // miss at 0x200, grant every cycle
    w0 = wr_cnt;
    run_fill(32'h200, 1'b1);
    chk("miss_word", last_inst, 32'h00100093);
    chk("miss_gnts", 32'(gnt_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      chk("miss_gnt_addr", gnt_log[i], 32'h200 + 32'(i));
    chk("miss_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    last_inst = 32'h0;
    gnt_log.delete();
    cyc(1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
    chk("rehit_word", last_inst, 32'h00100093);
    chk("rehit_no_gnt", 32'(gnt_log.size()), 32'd0);

    // stalled grants
    gnt_pol = 2; stall_cnt = 0;
    run_fill(32'h240, 1'b1);
    gnt_pol = 0;
    chk("stall_gnts", 32'(gnt_log.size()), 32'd4);
    if (gnt_log.size() == 4) chk("stall_last_addr", gnt_log[3], 32'h243);
    chk("stall_word", last_inst, exp_word(32'h240));

    // flush after 2 grants / 1 byte -> drain
    w0 = wr_cnt;
    gnt_log.delete();
    cyc(1'b1, 32'h280, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h280, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h280, 1'b0, 1'b1, 1'b0);
    hold_next = 1'b1;
    cyc(1'b0, 32'h280, 1'b1, 1'b1, 1'b0);
    chk("drain_gnts", 32'(gnt_log.size()), 32'd2);
    chkb("drain_no_req", mem_req, 1'b0);
    cyc(1'b0, 32'h280, 1'b0, 1'b1, 1'b0);
    chk("flush_no_wr", 32'(wr_cnt - w0), 32'd0);
    run_fill(32'h300, 1'b1);
    if (gnt_log.size() > 0) chk("post_flush_addr", gnt_log[0], 32'h300);
    chk("post_flush_word", last_inst, exp_word(32'h300));

    // rdy low for 5 cycles mid-miss
    gnt_log.delete(); last_inst = 32'h0;
    cyc(1'b1, 32'h340, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h340, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h340, 1'b0, 1'b1, 1'b0);
    repeat (5) cyc(1'b1, 32'h340, 1'b0, 1'b0, 1'b0);
    chk("rdy_freeze_addr", mem_addr, 32'h342);
    chk("rdy_freeze_gnts", 32'(gnt_log.size()), 32'd2);
    run_fill(32'h340, 1'b0);
    chk("rdy_word", last_inst, exp_word(32'h340));
    chk("rdy_gnts", 32'(gnt_log.size()), 32'd4);

    // async reset mid-miss
    w0 = wr_cnt;
    cyc(1'b1, 32'h380, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h380, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h380, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h380, 1'b0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 32'h380, 1'b0, 1'b1, 1'b0);
    chk("rst_no_wr", 32'(wr_cnt - w0), 32'd0);
    run_fill(32'h380, 1'b1);
    chk("rst_refill_gnts", 32'(gnt_log.size()), 32'd4);
    chk("rst_refill_word", last_inst, exp_word(32'h380));

    // address wrap at top of memory, low pc bits ignored
    run_fill(32'hFFFFFFFE, 1'b1);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      chk("wrap_gnt_addr", gnt_log[i], 32'hFFFFFFFC + 32'(i));
    chk("wrap_word", last_inst, exp_word(32'hFFFFFFFC));

    // flush during the response cycle still fills the icache
    w0 = wr_cnt;
    cyc(1'b1, 32'h3C0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 40 && !f_done; k++) cyc(1'b1, 32'h3C0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h3C0, 1'b1, 1'b1, 1'b0);
    chk("resp_flush_wr", 32'(wr_cnt - w0), 32'd1);
    last_inst = 32'h0;
    cyc(1'b1, 32'h3C0, 1'b0, 1'b1, 1'b0);
    chk("resp_flush_rehit", last_inst, exp_word(32'h3C0));

    // response cycle with fetch moved on: write but no hand-off
    w0 = wr_cnt;
    cyc(1'b1, 32'h400, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 40 && !f_done; k++) cyc(1'b1, 32'h400, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h404, 1'b0, 1'b1, 1'b0);
    chk("resp_pc_moved_wr", 32'(wr_cnt - w0), 32'd1);

    // flush in idle starts nothing
    cyc(1'b1, 32'h3E0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'h3E0, 1'b0, 1'b1, 1'b0);
    chkb("idle_flush_no_req", mem_req, 1'b0);

    // randomized traffic
    pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h240; pool[3] = 32'h500;
    pool[4] = 32'h504; pool[5] = 32'h508; pool[6] = 32'h90C; pool[7] = 32'hFFFFFFFC;
    gnt_pol = 1; rnd_data = 1'b1;
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 3) != 0),
          pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3)),
          ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 9) != 0),
          1'b0);
    end
    gnt_pol = 0; rnd_data = 1'b0;
    for (int k = 0; k < 40 && f_on; k++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chkb("random_settled", f_on, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
